pdet_scan_ctrl: RTL and testbench

PDET_SCAN_CTRL -- requirements
Module: pdet_scan_ctrl

---
 rtl/pdet_pkg.sv | 14 +
 rtl/pdet_serializer.sv | 38 +++
 rtl/pdet_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_pdet_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdet_pkg.sv
// Shared types and default widths for the pattern-detector scan controller.
package pdet_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pdet_serializer.sv
// MSB-first parallel-to-serial shifter with a per-word beat index; load wins over shift.
// One bit per cycle while shift is high; final_beat flags the last bit of the word.
module pdet_serializer
    import pdet_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift,
    output logic              msb,
    output logic              final_beat
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sreg_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            sreg_q <= word;
            idx_q  <= '0;
        end else if (shift) begin
            sreg_q <= sreg_q << 1;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign msb        = sreg_q[WORD_W-1];
    assign final_beat = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/pdet_scan_ctrl.sv
// Feeds framed words bit-serially to a detector and counts its hits; PDET_CTRL_IRQ_EN adds a threshold irq.
// First bit one cycle after accept; words back-to-back with no gap; ready drops for DRAIN/DONE at frame end.
module pdet_scan_ctrl
    import pdet_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              last_i,
    output logic              det_data_o,
    output logic              det_valid_o,
    output logic              det_rst_o,
    input  logic              det_hit_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic              busy_o,
    output logic              frame_done_o,
    input  logic [CNT_W-1:0]  thresh_i,
    output logic              irq_o,
    input  logic              irq_clr_i
);

    state_t            state_q, state_d;
    logic              last_q;
    logic              frame_open_q;
    logic              det_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              ser_msb;
    logic              ser_final;
    logic              hit_inc;
    logic              cnt_sat;

    assign accept  = word_valid_i & word_ready_o;
    assign hit_inc = det_hit_i & det_valid_q;
    assign cnt_sat = &cnt_q;

    pdet_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (accept),
        .word       (word_i),
        .shift      (state_q == ST_SHIFT),
        .msb        (ser_msb),
        .final_beat (ser_final)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (ser_final) begin
                    if (last_q)       state_d = ST_DRAIN;
                    else if (!accept) state_d = ST_IDLE;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced to their reset values for as long as rst_i is held.
    always_comb begin
        word_ready_o = 1'b0;
        det_valid_o  = 1'b0;
        det_data_o   = 1'b0;
        det_rst_o    = rst_i;
        frame_done_o = 1'b0;
        busy_o       = 1'b0;
        if (!rst_i) begin
            busy_o = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE:  word_ready_o = 1'b1;
                ST_SHIFT: begin
                    det_valid_o  = 1'b1;
                    det_data_o   = ser_msb;
                    word_ready_o = ser_final & ~last_q;
                end
                ST_DONE: begin
                    frame_done_o = 1'b1;
                    det_rst_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The detector answers one cycle late, so det_valid_q qualifies the hit input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= 1'b0;
            frame_open_q <= 1'b0;
            det_valid_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            det_valid_q <= det_valid_o;
            if (accept) begin
                last_q       <= last_i;
                frame_open_q <= 1'b1;
            end else if (state_q == ST_DONE) begin
                frame_open_q <= 1'b0;
            end
            if (accept && !frame_open_q)  cnt_q <= '0;
            else if (hit_inc && !cnt_sat) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_cnt_o = cnt_q;

`ifdef PDET_CTRL_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = hit_inc & ~cnt_sat & (thresh_i != '0) &
                     ((cnt_q + CNT_W'(1)) == thresh_i);

    always_ff @(posedge clk_i) begin
        if (rst_i)          irq_q <= 1'b0;
        else if (irq_set)   irq_q <= 1'b1;
        else if (irq_clr_i) irq_q <= 1'b0;
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{thresh_i, irq_clr_i};
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pdet_scan_ctrl.sv
// Directed-vector bench: stimulus pushes expected bits/frames, a negedge monitor pops and compares.
module tb_pdet_scan_ctrl;

    localparam int WW = 8;
    localparam int CW = 16;

    typedef struct {
        int cnt;
        int cnt2;
        int run;
        int rise;
    } frame_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [WW-1:0] word_i;
    logic          word_valid_i;
    logic          last_i;
    logic [CW-1:0] thresh_i;
    logic [1:0]    thresh2;
    logic          spur_hit;
    logic          stub_hit = 1'b0;
    logic          stub_clr = 1'b0;
    logic          det_hit_i;
    logic          irq_clr_i;

    logic          word_ready_o, det_data_o, det_valid_o, det_rst_o;
    logic          busy_o, frame_done_o, irq_o;
    logic [CW-1:0] hit_cnt_o;
    logic          r2, d2, v2, rs2, b2, fd2, i2;
    logic [1:0]    cnt2;

    logic [63:0]   hit_mask;
    logic [63:0]   clr_mask;
    int            beat_n = 0;

    int            tests = 0;
    int            fails = 0;
    int            done_cnt = 0;
    bit            exp_bits[$];
    frame_t        exp_frames[$];

    always #5 clk_i = ~clk_i;

    assign det_hit_i = stub_hit | spur_hit;
    assign irq_clr_i = stub_clr;

    pdet_scan_ctrl #(.WORD_W(WW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o), .last_i(last_i), .det_data_o(det_data_o),
        .det_valid_o(det_valid_o), .det_rst_o(det_rst_o), .det_hit_i(det_hit_i),
        .hit_cnt_o(hit_cnt_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .thresh_i(thresh_i), .irq_o(irq_o), .irq_clr_i(irq_clr_i)
    );

    pdet_scan_ctrl #(.WORD_W(WW), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(r2), .last_i(last_i), .det_data_o(d2),
        .det_valid_o(v2), .det_rst_o(rs2), .det_hit_i(det_hit_i),
        .hit_cnt_o(cnt2), .busy_o(b2), .frame_done_o(fd2),
        .thresh_i(thresh2), .irq_o(i2), .irq_clr_i(irq_clr_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered detector stub: hit/clear fire the cycle after the masked beat number.
    always @(posedge clk_i) begin
        if (rst_i || frame_done_o) begin
            beat_n   <= 0;
            stub_hit <= 1'b0;
            stub_clr <= 1'b0;
        end else begin
            stub_hit <= det_valid_o && hit_mask[beat_n + 1];
            stub_clr <= det_valid_o && clr_mask[beat_n + 1];
            if (det_valid_o) beat_n <= beat_n + 1;
        end
    end

    int     mon_beat = 0, cur_run = 0, max_run = 0, rise = -1;
    bit     pv1 = 1'b0, pv2 = 1'b0, prev_irq = 1'b0;
    bit     eb;
    frame_t ef;

    always @(negedge clk_i) begin
        if (rst_i) begin
            mon_beat = 0; cur_run = 0; max_run = 0; rise = -1;
            pv1 = 1'b0; pv2 = 1'b0; prev_irq = 1'b0;
        end else begin
            if (det_valid_o) begin
                mon_beat++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (exp_bits.size() == 0) check("extra_beat", 32'd1, 32'd0);
                else begin
                    eb = exp_bits.pop_front();
                    check("det_data", 32'(det_data_o), 32'(eb));
                end
            end else begin
                cur_run = 0;
            end
            if (irq_o && !prev_irq && rise < 0) rise = mon_beat;
            prev_irq = irq_o;
            if (frame_done_o) begin
                if (exp_frames.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    ef = exp_frames.pop_front();
                    check("hit_cnt", 32'(hit_cnt_o), ef.cnt);
                    check("hit_cnt_sat", 32'(cnt2), ef.cnt2);
                    check("beat_run", max_run, ef.run);
                    check("irq_rise_beat", rise, ef.rise);
                    check("done_det_rst", 32'(det_rst_o), 32'd1);
                    check("drain_gap", 32'({pv2, pv1}), 32'd2);
                end
                done_cnt++;
                mon_beat = 0; max_run = 0; rise = -1;
            end
            pv2 = pv1;
            pv1 = det_valid_o;
        end
    end

    task automatic send_word(input logic [WW-1:0] w, input logic last, input bit hold, input int nexp);
        int n;
        for (int i = 0; i < nexp; i++) exp_bits.push_back(w[WW-1-i]);
        word_i = w;
        last_i = last;
        word_valid_i = 1'b1;
        n = 0;
        while (!word_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        if (!hold) word_valid_i = 1'b0;
    endtask

    task automatic expect_frame(input int cnt, input int run, input int rise_beat);
        frame_t f;
        f.cnt  = cnt;
        f.cnt2 = (cnt > 3) ? 3 : cnt;
        f.run  = run;
        f.rise = rise_beat;
        exp_frames.push_back(f);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames;
        int n;
        frames = 0;
        rst_i = 1'b1; word_valid_i = 1'b0; word_i = '0; last_i = 1'b0;
        thresh_i = '0; thresh2 = '0; spur_hit = 1'b0;
        hit_mask = '0; clr_mask = '0;

        repeat (3) @(negedge clk_i);
        check("rst_ctrl", 32'({word_ready_o, det_valid_o, det_data_o, det_rst_o,
                               busy_o, frame_done_o, irq_o}), 32'h08);
        check("rst_cnt", 32'(hit_cnt_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", 32'(word_ready_o), 32'd1);
        check("idle_det_rst", 32'(det_rst_o), 32'd0);

        // Single word 0x49, hit after beat 5
        hit_mask = 64'd1 << 5;
        expect_frame(1, 8, -1);
        send_word(8'h49, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);
        repeat (3) @(negedge clk_i);
        check("cnt_hold_after_done", 32'(hit_cnt_o), 32'd1);
        check("idle_not_busy", 32'(busy_o), 32'd0);

        // Back-to-back 0xFF, 0x00(last), hits after beats 3 and 12
        hit_mask = (64'd1 << 3) | (64'd1 << 12);
        expect_frame(2, 16, -1);
        send_word(8'hFF, 1'b0, 1'b1, 8);
        send_word(8'h00, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);

        // Hit following the final beat is captured in DRAIN
        hit_mask = 64'd1 << 8;
        expect_frame(1, 8, -1);
        send_word(8'hA5, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);

        // Five hits: 16-bit counter reads 5, 2-bit counter saturates at 3
        hit_mask = 64'h3E;
        expect_frame(5, 8, -1);
        send_word(8'hF0, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);

        // Open frame with an idle gap; a stray hit in the gap is ignored
        hit_mask = (64'd1 << 2) | (64'd1 << 10);
        expect_frame(2, 8, -1);
        send_word(8'h3C, 1'b0, 1'b0, 8);
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("gap_idle", 32'(busy_o), 32'd0);
        check("gap_cnt", 32'(hit_cnt_o), 32'd1);
        repeat (2) @(negedge clk_i);
        spur_hit = 1'b1;
        @(negedge clk_i);
        spur_hit = 1'b0;
        @(negedge clk_i);
        check("spur_ignored", 32'(hit_cnt_o), 32'd1);
        send_word(8'hC3, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);
        check("gap_frame_cnt_hold", 32'(hit_cnt_o), 32'd2);

        // Threshold 2, hits after beats 2/4/6, clear pulsed alongside hit 3
        thresh_i = 16'd2;
        hit_mask = (64'd1 << 2) | (64'd1 << 4) | (64'd1 << 6);
        clr_mask = 64'd1 << 6;
`ifdef PDET_CTRL_IRQ_EN
        expect_frame(3, 8, 6);
`else
        expect_frame(3, 8, -1);
`endif
        send_word(8'h55, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);
        check("irq_after_clr", 32'(irq_o), 32'd0);
        thresh_i = '0;
        clr_mask = '0;

        // Reset during beat 4 aborts the frame and its partial count
        hit_mask = 64'd1 << 1;
        send_word(8'hFF, 1'b1, 1'b0, 3);
        @(negedge clk_i);
        @(negedge clk_i);
        check("pre_rst_cnt", 32'(hit_cnt_o), 32'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_gate", 32'({word_ready_o, det_valid_o, det_data_o, det_rst_o,
                               busy_o, frame_done_o, irq_o}), 32'h08);
        @(negedge clk_i);
        check("rst_mid_ctrl", 32'({word_ready_o, det_valid_o, det_data_o, det_rst_o,
                                   busy_o, frame_done_o, irq_o}), 32'h08);
        check("rst_mid_cnt", 32'(hit_cnt_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        hit_mask = 64'd1 << 1;
        expect_frame(1, 8, -1);
        send_word(8'h81, 1'b1, 1'b0, 8);
        frames++; wait_done(frames);

        check("bits_left", exp_bits.size(), 32'd0);
        check("frames_left", exp_frames.size(), 32'd0);
        check("done_count", done_cnt, frames);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
